control_memory_config: RTL and testbench

- Write-side controller for the per-thread branch control memory, whose word is packed {match, condition, link} with match in the MSBs.
- Arbitrates between two configuration requesters: A, the software I/O write path, and B, the bulk loader/debug port.
- Supports field-granular updates through a per-thread shadow copy, merging each field write into a full word.
- Provides a clear sweep that zeroes every thread entry.
- Drives the control memory's wren / write_thread / write_data, one registered write per cycle.

---
 rtl/control_memory_config.sv | 160 ++++++++++++++++
 tb/tb_control_memory_config.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_memory_config.sv
// Write-side controller for the per-thread branch control memory: arbitrates two
// configuration requesters, merges field writes through a shadow copy, and runs a clear sweep.
module control_memory_config #(
    parameter int unsigned MATCH_WIDTH  = 10,
    parameter int unsigned COND_WIDTH   = 4,
    parameter int unsigned LINK_WIDTH   = 10,
    parameter int unsigned THREAD_COUNT = 8,
    parameter int unsigned THREAD_WIDTH = 3,
    localparam int unsigned WORD_WIDTH  = MATCH_WIDTH + COND_WIDTH + LINK_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [THREAD_WIDTH-1:0] a_thread,
    input  logic [1:0]              a_field,
    input  logic [WORD_WIDTH-1:0]   a_data,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [THREAD_WIDTH-1:0] b_thread,
    input  logic [1:0]              b_field,
    input  logic [WORD_WIDTH-1:0]   b_data,
    input  logic                    clear_start,
    output logic                    clear_busy,
    output logic                    wren,
    output logic [THREAD_WIDTH-1:0] write_thread,
    output logic [WORD_WIDTH-1:0]   write_data
);

    localparam int unsigned DEPTH     = 2 ** THREAD_WIDTH;
    localparam int unsigned LINK_LSB  = 0;
    localparam int unsigned COND_LSB  = LINK_WIDTH;
    localparam int unsigned MATCH_LSB = LINK_WIDTH + COND_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [THREAD_WIDTH-1:0] cnt_q, cnt_d;
    logic                    prio_a_q, prio_a_d;

    logic [WORD_WIDTH-1:0]   shadow [DEPTH];
    logic [DEPTH-1:0]        shadow_valid;

    logic                    serve, grant_a, grant_b, in_range;
    logic [THREAD_WIDTH-1:0] sel_thread;
    logic [1:0]              sel_field;
    logic [WORD_WIDTH-1:0]   sel_data, base, merged;

    logic                    wren_d;
    logic [THREAD_WIDTH-1:0] thread_d;
    logic [WORD_WIDTH-1:0]   data_d;
    logic                    sh_we;
    logic [THREAD_WIDTH-1:0] sh_idx;
    logic [WORD_WIDTH-1:0]   sh_val;

    // Round-robin arbitration; requesters are only served in IDLE with no sweep starting
    always_comb begin
        serve   = (state_q == IDLE) && !clear_start && !reset;
        grant_a = serve && a_valid && (!b_valid || prio_a_q);
        grant_b = serve && b_valid && (!a_valid || !prio_a_q);
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Merge the selected field into the thread's shadow word (zero base if never written)
    always_comb begin
        sel_thread = grant_b ? b_thread : a_thread;
        sel_field  = grant_b ? b_field  : a_field;
        sel_data   = grant_b ? b_data   : a_data;
        in_range   = 32'(sel_thread) < THREAD_COUNT;
        base       = shadow_valid[sel_thread] ? shadow[sel_thread] : '0;
        merged     = base;
        case (sel_field)
            2'd0:    merged[MATCH_LSB +: MATCH_WIDTH] = sel_data[MATCH_WIDTH-1:0];
            2'd1:    merged[COND_LSB +: COND_WIDTH]   = sel_data[COND_WIDTH-1:0];
            2'd2:    merged[LINK_LSB +: LINK_WIDTH]   = sel_data[LINK_WIDTH-1:0];
            default: merged = sel_data;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prio_a_d = prio_a_q;
        wren_d   = 1'b0;
        thread_d = write_thread;
        data_d   = write_data;
        sh_we    = 1'b0;
        sh_idx   = sel_thread;
        sh_val   = merged;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (grant_a || grant_b) begin
                    prio_a_d = grant_b;
                    if (in_range) begin
                        wren_d   = 1'b1;
                        thread_d = sel_thread;
                        data_d   = merged;
                        sh_we    = 1'b1;
                    end
                end
            end
            CLEAR: begin
                wren_d   = 1'b1;
                thread_d = cnt_q;
                data_d   = '0;
                sh_we    = 1'b1;
                sh_idx   = cnt_q;
                sh_val   = '0;
                if (32'(cnt_q) == THREAD_COUNT - 1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + THREAD_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            prio_a_q     <= 1'b1;
            wren         <= 1'b0;
            write_thread <= '0;
            write_data   <= '0;
            clear_busy   <= 1'b0;
            shadow_valid <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prio_a_q     <= prio_a_d;
            wren         <= wren_d;
            write_thread <= thread_d;
            write_data   <= data_d;
            clear_busy   <= (state_d == CLEAR);
            if (sh_we) begin
                shadow_valid[sh_idx] <= 1'b1;
            end
        end
    end

    // Shadow contents need no reset; validity is tracked separately
    always_ff @(posedge clock) begin
        if (sh_we && !reset) begin
            shadow[sh_idx] <= sh_val;
        end
    end

endmodule

// File: tb/tb_control_memory_config.sv
// Bench for control_memory_config: directed vector table, clear-sweep sequences,
// and randomized traffic checked against a per-cycle behavioural model.
module tb_control_memory_config;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [2:0]  a_thread, b_thread;
    logic [1:0]  a_field, b_field;
    logic [23:0] a_data, b_data;
    logic        clear_start, clear_busy, wren;
    logic [2:0]  write_thread;
    logic [23:0] write_data;

    always #5 clock = ~clock;

    control_memory_config dut (
        .clock        (clock),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_thread     (a_thread),
        .a_field      (a_field),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_thread     (b_thread),
        .b_field      (b_field),
        .b_data       (b_data),
        .clear_start  (clear_start),
        .clear_busy   (clear_busy),
        .wren         (wren),
        .write_thread (write_thread),
        .write_data   (write_data)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: word = match*2^14 + cond*2^10 + link
    logic [23:0] m_sh [8];
    bit          m_vl [8];
    bit          m_clearing = 1'b0;
    int          m_idx = 0;
    bit          m_prio_a = 1'b1;
    bit          m_ar, m_br, m_wren, m_busy;
    logic [2:0]  m_wt;
    logic [23:0] m_wd;

    function automatic logic [23:0] merge(input logic [23:0] base, input logic [1:0] f,
                                          input logic [23:0] d);
        int m, c, l;
        m = int'(base) / 16384;
        c = (int'(base) / 1024) % 16;
        l = int'(base) % 1024;
        case (f)
            2'd0: m = int'(d) % 1024;
            2'd1: c = int'(d) % 16;
            2'd2: l = int'(d) % 1024;
            default: return d;
        endcase
        return 24'(m * 16384 + c * 1024 + l);
    endfunction

    task automatic model_update();
        bit ok;
        int t;
        ok   = !m_clearing && !clear_start && !reset;
        m_ar = ok && a_valid && (!b_valid || m_prio_a);
        m_br = ok && b_valid && (!a_valid || !m_prio_a);
        if (reset) begin
            m_clearing = 1'b0; m_idx = 0; m_prio_a = 1'b1;
            foreach (m_vl[i]) m_vl[i] = 1'b0;
            m_wren = 1'b0; m_wt = 3'd0; m_wd = 24'd0; m_busy = 1'b0;
        end else if (m_clearing) begin
            m_wren = 1'b1; m_wt = 3'(m_idx); m_wd = 24'd0;
            m_sh[m_idx] = 24'd0; m_vl[m_idx] = 1'b1;
            m_idx++;
            if (m_idx == 8) begin
                m_clearing = 1'b0;
                m_idx = 0;
            end
            m_busy = m_clearing;
        end else if (clear_start) begin
            m_clearing = 1'b1; m_idx = 0; m_wren = 1'b0; m_busy = 1'b1;
        end else if (m_ar || m_br) begin
            t = m_ar ? int'(a_thread) : int'(b_thread);
            m_wd = merge(m_vl[t] ? m_sh[t] : 24'd0, m_ar ? a_field : b_field,
                         m_ar ? a_data : b_data);
            m_sh[t] = m_wd; m_vl[t] = 1'b1;
            m_wren = 1'b1; m_wt = 3'(t); m_busy = 1'b0;
            m_prio_a = m_br;
        end else begin
            m_wren = 1'b0; m_busy = 1'b0;
        end
    endtask

    bit          o_ar, o_br, o_w, o_busy;
    logic [2:0]  o_wt;
    logic [23:0] o_wd;

    // One clock: sample readies before the edge, outputs just after it
    task automatic step();
        #1;
        o_ar = a_ready;
        o_br = b_ready;
        model_update();
        @(posedge clock);
        #1;
        o_w = wren; o_wt = write_thread; o_wd = write_data; o_busy = clear_busy;
        @(negedge clock);
    endtask

    task automatic set_in(input int rst, input int av, input int at, input int af, input int ad,
                          input int bv, input int bt, input int bf, input int bd, input int cs);
        reset = 1'(rst); clear_start = 1'(cs);
        a_valid = 1'(av); a_thread = 3'(at); a_field = 2'(af); a_data = 24'(ad);
        b_valid = 1'(bv); b_thread = 3'(bt); b_field = 2'(bf); b_data = 24'(bd);
    endtask

    typedef struct {
        int rst, av, at, af, ad, bv, bt, bf, bd, cs;
        int ar, br, w, wt, wd, busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int rst, int av, int at, int af, int ad, int bv, int bt, int bf,
                                int bd, int cs, int ar, int br, int w, int wt, int wd, int busy);
        vec_t v;
        v.rst = rst; v.av = av; v.at = at; v.af = af; v.ad = ad;
        v.bv = bv; v.bt = bt; v.bf = bf; v.bd = bd; v.cs = cs;
        v.ar = ar; v.br = br; v.w = w; v.wt = wt; v.wd = wd; v.busy = busy;
        return v;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_a_ready"}, 32'(o_ar), 32'(m_ar));
        chk({tag, "_b_ready"}, 32'(o_br), 32'(m_br));
        chk({tag, "_wren"}, 32'(o_w), 32'(m_wren));
        chk({tag, "_clear_busy"}, 32'(o_busy), 32'(m_busy));
        if (m_wren) begin
            chk({tag, "_write_thread"}, 32'(o_wt), 32'(m_wt));
            chk({tag, "_write_data"}, 32'(o_wd), 32'(m_wd));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl.push_back(mk(1, 0,0,0,0,         0,0,0,0,         0, 0,0,0,0,0,0));
        tbl.push_back(mk(0, 1,2,3,'h0ABCDE,  0,0,0,0,         0, 1,0,1,2,'h0ABCDE,0));
        tbl.push_back(mk(0, 1,2,1,'h5,       0,0,0,0,         0, 1,0,1,2,'h0A94DE,0));
        tbl.push_back(mk(0, 1,2,2,'h3FF,     0,0,0,0,         0, 1,0,1,2,'h0A97FF,0));
        tbl.push_back(mk(1, 0,0,0,0,         0,0,0,0,         0, 0,0,0,0,0,0));
        tbl.push_back(mk(0, 1,1,3,'h111111,  1,3,3,'h222222,  0, 1,0,1,1,'h111111,0));
        tbl.push_back(mk(0, 1,1,3,'h111111,  1,3,3,'h222222,  0, 0,1,1,3,'h222222,0));
        tbl.push_back(mk(0, 1,1,3,'h111111,  1,3,3,'h222222,  0, 1,0,1,1,'h111111,0));
        tbl.push_back(mk(0, 1,1,3,'h111111,  1,3,3,'h222222,  0, 0,1,1,3,'h222222,0));
        tbl.push_back(mk(0, 1,5,0,'h155,     0,0,0,0,         0, 1,0,1,5,'h554000,0));
        tbl.push_back(mk(0, 0,0,0,0,         0,0,0,0,         0, 0,0,0,0,0,0));

        foreach (tbl[i]) begin
            set_in(tbl[i].rst, tbl[i].av, tbl[i].at, tbl[i].af, tbl[i].ad,
                   tbl[i].bv, tbl[i].bt, tbl[i].bf, tbl[i].bd, tbl[i].cs);
            step();
            chk($sformatf("vec%0d_a_ready", i), 32'(o_ar), 32'(tbl[i].ar));
            chk($sformatf("vec%0d_b_ready", i), 32'(o_br), 32'(tbl[i].br));
            chk($sformatf("vec%0d_wren", i), 32'(o_w), 32'(tbl[i].w));
            chk($sformatf("vec%0d_clear_busy", i), 32'(o_busy), 32'(tbl[i].busy));
            if (tbl[i].w != 0) begin
                chk($sformatf("vec%0d_write_thread", i), 32'(o_wt), 32'(tbl[i].wt));
                chk($sformatf("vec%0d_write_data", i), 32'(o_wd), 32'(tbl[i].wd));
            end
        end

        // Clear sweep with A held pending throughout
        set_in(0, 1, 0, 3, 'h123456, 0, 0, 0, 0, 1);
        step();
        chk("clr_start_a_ready", 32'(o_ar), 32'd0);
        chk("clr_start_wren", 32'(o_w), 32'd0);
        chk("clr_start_busy", 32'(o_busy), 32'd1);
        set_in(0, 1, 0, 3, 'h123456, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("clr%0d_a_ready", i), 32'(o_ar), 32'd0);
            chk($sformatf("clr%0d_wren", i), 32'(o_w), 32'd1);
            chk($sformatf("clr%0d_write_thread", i), 32'(o_wt), 32'(i));
            chk($sformatf("clr%0d_write_data", i), 32'(o_wd), 32'd0);
            chk($sformatf("clr%0d_busy", i), 32'(o_busy), (i < 7) ? 32'd1 : 32'd0);
        end
        step();
        chk("clr_after_a_ready", 32'(o_ar), 32'd1);
        chk("clr_after_wren", 32'(o_w), 32'd1);
        chk("clr_after_write_thread", 32'(o_wt), 32'd0);
        chk("clr_after_write_data", 32'(o_wd), 32'h123456);

        // Reset in sweep cycle 3, then a partial write to thread 6
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        chk("rclr_start_busy", 32'(o_busy), 32'd1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("rclr%0d_write_thread", i), 32'(o_wt), 32'(i));
        end
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("rclr_reset_wren", 32'(o_w), 32'd0);
        chk("rclr_reset_busy", 32'(o_busy), 32'd0);
        set_in(0, 1, 6, 1, 'h9, 0, 0, 0, 0, 0);
        step();
        chk("rclr_t6_a_ready", 32'(o_ar), 32'd1);
        chk("rclr_t6_wren", 32'(o_w), 32'd1);
        chk("rclr_t6_write_thread", 32'(o_wt), 32'd6);
        chk("rclr_t6_write_data", 32'(o_wd), 32'h002400);

        // Randomized traffic; a pending request is held until accepted
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        o_ar = 1'b0; o_br = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!a_valid || o_ar) begin
                a_valid  = 1'($urandom_range(0, 1));
                a_thread = 3'($urandom_range(0, 7));
                a_field  = 2'($urandom_range(0, 3));
                a_data   = 24'($urandom);
            end
            if (!b_valid || o_br) begin
                b_valid  = 1'($urandom_range(0, 1));
                b_thread = 3'($urandom_range(0, 7));
                b_field  = 2'($urandom_range(0, 3));
                b_data   = 24'($urandom);
            end
            clear_start = ($urandom_range(0, 39) == 0);
            reset       = ($urandom_range(0, 79) == 0);
            step();
            check_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
